pwm_sample_decoder: RTL and testbench

PWM_SAMPLE_DECODER -- requirements
Module: pwm_sample_decoder

---
 rtl/pwm_sample_decoder.sv | 128 ++++++++++++
 tb/tb_pwm_sample_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sample_decoder.sv
// PWM audio decoder: aligns to frame-start rising edges, counts high cycles per
// 2^FRAME_BITS-cycle frame, and reports duty samples, sync errors and silence.
module pwm_sample_decoder #(
  parameter int FRAME_BITS    = 8,
  parameter int SILENT_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pwm_in,
  output logic [FRAME_BITS-1:0] sample,
  output logic                  sample_valid,
  output logic                  locked,
  output logic                  sync_err,
  output logic [7:0]            err_count,
  output logic                  silent
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  localparam logic [FRAME_BITS-1:0] POS_LAST   = '1;
  localparam logic [FRAME_BITS-1:0] POS_ONE    = FRAME_BITS'(1);
  localparam logic [FRAME_BITS:0]   CNT_ONE    = (FRAME_BITS+1)'(1);
  localparam logic [FRAME_BITS:0]   CNT_FULL   = {1'b1, {FRAME_BITS{1'b0}}};
  localparam logic [7:0]            SILENT_LIM = 8'(SILENT_FRAMES);

  state_t                state_q, state_d;
  logic                  prev_q, prev_d;
  logic [FRAME_BITS-1:0] pos_q, pos_d;
  logic [FRAME_BITS:0]   high_cnt_q, high_cnt_d;
  logic [FRAME_BITS-1:0] sample_q, sample_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  sync_err_q, sync_err_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [7:0]            zero_run_q, zero_run_d;

  logic                  rise;
  logic [FRAME_BITS:0]   frame_total;

  always_comb begin
    rise           = pwm_in & ~prev_q;
    frame_total    = high_cnt_q + {{FRAME_BITS{1'b0}}, pwm_in};
    state_d        = state_q;
    prev_d         = pwm_in;
    pos_d          = pos_q;
    high_cnt_d     = high_cnt_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    sync_err_d     = 1'b0;

    case (state_q)
      HUNT: begin
        // The locking edge itself is position 0 and contributes one high cycle.
        if (rise) begin
          state_d    = LOCKED;
          pos_d      = POS_ONE;
          high_cnt_d = CNT_ONE;
        end
      end
      LOCKED: begin
        if (rise && (pos_q != '0)) begin
          sync_err_d = 1'b1;
          pos_d      = POS_ONE;
          high_cnt_d = CNT_ONE;
        end else if (pos_q == POS_LAST) begin
          sample_valid_d = 1'b1;
          sync_err_d     = (frame_total == CNT_FULL);
          sample_d       = (frame_total == CNT_FULL) ? POS_LAST : frame_total[FRAME_BITS-1:0];
          pos_d          = '0;
          high_cnt_d     = '0;
        end else begin
          pos_d      = pos_q + POS_ONE;
          high_cnt_d = frame_total;
        end
      end
      default: state_d = HUNT;
    endcase

    err_count_d = err_count_q;
    if (sync_err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    // Zero-run count only needs to reach the threshold, so it saturates there.
    zero_run_d = zero_run_q;
    if (sample_valid_d) begin
      if (sample_d != '0) begin
        zero_run_d = 8'd0;
      end else if (zero_run_q < SILENT_LIM) begin
        zero_run_d = zero_run_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= HUNT;
      prev_q         <= 1'b1;
      pos_q          <= '0;
      high_cnt_q     <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sync_err_q     <= 1'b0;
      err_count_q    <= 8'd0;
      zero_run_q     <= 8'd0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      pos_q          <= pos_d;
      high_cnt_q     <= high_cnt_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      sync_err_q     <= sync_err_d;
      err_count_q    <= err_count_d;
      zero_run_q     <= zero_run_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign locked       = (state_q == LOCKED);
  assign sync_err     = sync_err_q;
  assign err_count    = err_count_q;
  assign silent       = (zero_run_q >= SILENT_LIM);

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Scoreboard bench for pwm_sample_decoder: a frame-level reference model queues
// expected sample/error events that a negedge monitor compares against the DUT.
module tb_pwm_sample_decoder;

  localparam int FRAME_BITS = 8;
  localparam int F          = 1 << FRAME_BITS;
  localparam int SILENT_N   = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  pwm_in = 1'b0;
  logic [FRAME_BITS-1:0] sample;
  logic                  sample_valid;
  logic                  locked;
  logic                  sync_err;
  logic [7:0]            err_count;
  logic                  silent;

  pwm_sample_decoder #(
    .FRAME_BITS   (FRAME_BITS),
    .SILENT_FRAMES(SILENT_N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .sample      (sample),
    .sample_valid(sample_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .err_count   (err_count),
    .silent      (silent)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    bit          valid;
    bit          err;
    int          smp;
    int          errs;
    bit          sil;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  // Reference model state: levels seen so far in the current frame.
  bit m_locked = 0;
  bit m_prev = 1;
  bit frame_lv[$];
  int m_zero = 0;
  int m_errs = 0;
  bit check_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushEvent(input bit valid, input bit err, input int smp);
    ev_t e;
    if (err) m_errs = (m_errs < 255) ? m_errs + 1 : 255;
    if (valid) m_zero = (smp == 0) ? m_zero + 1 : 0;
    e.cyc   = cyc + 1;
    e.valid = valid;
    e.err   = err;
    e.smp   = smp;
    e.errs  = m_errs;
    e.sil   = (m_zero >= SILENT_N);
    sb.push_back(e);
  endtask

  task automatic modelStep(input bit level, input bit rst);
    bit rise;
    int total;
    if (rst) begin
      m_locked = 0;
      m_prev   = 1;
      m_zero   = 0;
      m_errs   = 0;
      frame_lv.delete();
      return;
    end
    rise   = level && !m_prev;
    m_prev = level;
    if (!m_locked) begin
      if (rise) begin
        m_locked = 1;
        frame_lv.delete();
        frame_lv.push_back(level);
      end
    end else if (rise && frame_lv.size() != 0) begin
      pushEvent(0, 1, 0);
      frame_lv.delete();
      frame_lv.push_back(level);
    end else begin
      frame_lv.push_back(level);
      if (frame_lv.size() == F) begin
        total = 0;
        foreach (frame_lv[i]) total += int'(frame_lv[i]);
        pushEvent(1, total == F, (total > F - 1) ? F - 1 : total);
        frame_lv.delete();
      end
    end
  endtask

  task automatic applyStimulus(input bit level, input bit rst);
    @(posedge clk);
    #1;
    if (check_en) checkOutput("locked", int'(locked), int'(m_locked));
    check_en = 1;
    pwm_in = level;
    reset  = rst;
    modelStep(level, rst);
  endtask

  task automatic driveFrames(input int duty, input int n);
    for (int f = 0; f < n; f++)
      for (int p = 0; p < F; p++) applyStimulus(p < duty, 0);
  endtask

  task automatic driveIdle(input bit level, input int n);
    for (int i = 0; i < n; i++) applyStimulus(level, 0);
  endtask

  task automatic applyReset(input bit level, input int n);
    for (int i = 0; i < n; i++) applyStimulus(level, 1);
  endtask

  // Monitor: every DUT event must match the head of the scoreboard, on time.
  int hold_smp = 0;
  bit hold_en = 0;
  always @(negedge clk) begin
    ev_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL missing_event: got none, want event due at cycle %0d (now %0d)", sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (sample_valid === 1'b1 || sync_err === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL spurious_event: got valid=%0b err=%0b, want no event (cycle %0d)", sample_valid, sync_err, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("event_cycle", int'(cyc), int'(e.cyc));
        checkOutput("sample_valid", int'(sample_valid), int'(e.valid));
        checkOutput("sync_err", int'(sync_err), int'(e.err));
        if (e.valid) begin
          checkOutput("sample", int'(sample), e.smp);
          hold_smp = e.smp;
        end
        checkOutput("err_count", int'(err_count), e.errs);
        checkOutput("silent", int'(silent), int'(e.sil));
      end
    end else if (reset === 1'b1) begin
      hold_smp = 0;
      hold_en  = 1;
    end else if (hold_en) begin
      checkOutput("sample_hold", int'(sample), hold_smp);
    end
  end

  initial begin
    applyReset(0, 3);
    checkOutput("rst_sample", int'(sample), 0);
    checkOutput("rst_valid", int'(sample_valid), 0);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_sync_err", int'(sync_err), 0);
    checkOutput("rst_err_count", int'(err_count), 0);
    checkOutput("rst_silent", int'(silent), 0);

    driveIdle(0, 5);
    driveFrames(100, 5);

    driveFrames(255, 2);
    driveFrames(1, 2);
    driveFrames(0, 5);
    driveFrames(30, 2);
    checkOutput("err_count_clean", int'(err_count), 0);
    checkOutput("silent_cleared", int'(silent), 0);

    driveFrames(50, 2);
    for (int p = 0; p < 77; p++) applyStimulus(p < 50, 0);
    driveFrames(50, 3);
    checkOutput("err_count_one", int'(err_count), 1);

    driveFrames(50, 1);
    driveIdle(1, F);
    driveFrames(50, 2);

    driveFrames(200, 1);
    for (int p = 0; p < 120; p++) applyStimulus(1, 0);
    applyReset(1, 3);
    driveIdle(1, 2);
    checkOutput("locked_after_reset", int'(locked), 0);
    driveIdle(1, 40);
    driveIdle(0, 20);
    driveFrames(200, 3);

    repeat (12) begin
      if ($urandom_range(0, 3) == 0)
        for (int p = 0; p < int'($urandom_range(1, F - 1)); p++) applyStimulus(p < 20, 0);
      driveFrames(int'($urandom_range(0, F)), 1);
    end

    driveFrames(50, 1);
    repeat (301) begin
      applyStimulus(1, 0);
      applyStimulus(0, 0);
    end
    driveIdle(0, 10);
    checkOutput("err_count_sat", int'(err_count), 255);

    driveIdle(0, 5);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
